// File: rtl/network_mac_pipe.sv
// Pipelined signed multiply-accumulate with frame delimiting, round-half-up
// rescaling and saturating output for one dot product per frame.
module network_mac_pipe #(
    parameter int A_WIDTH    = 15,
    parameter int B_WIDTH    = 16,
    parameter int NUM_STAGE  = 3,
    parameter int ACC_WIDTH  = 40,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAC_SHIFT = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ce,
    input  logic                        in_valid,
    input  logic signed [A_WIDTH-1:0]   in_a,
    input  logic signed [B_WIDTH-1:0]   in_b,
    input  logic                        in_first,
    input  logic                        in_last,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_sat
);

    localparam int PW = A_WIDTH + B_WIDTH;
    localparam int SW = ACC_WIDTH + 1;
    localparam int TOP = NUM_STAGE - 1;

    localparam logic signed [SW-1:0] ONE     = {{(SW-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] ACC_MAX = (ONE <<< (ACC_WIDTH-1)) - ONE;
    localparam logic signed [SW-1:0] ACC_MIN = -(ONE <<< (ACC_WIDTH-1));
    localparam logic signed [SW-1:0] OUT_MAX = (ONE <<< (OUT_WIDTH-1)) - ONE;
    localparam logic signed [SW-1:0] OUT_MIN = -(ONE <<< (OUT_WIDTH-1));
    localparam logic signed [SW-1:0] ROUND   = ONE <<< ((FRAC_SHIFT > 0) ? FRAC_SHIFT-1 : 0);

    // Operand registers and product pipe; slot 0 holds the raw product.
    logic signed [A_WIDTH-1:0] r_a;
    logic signed [B_WIDTH-1:0] r_b;
    logic signed [PW-1:0]      r_pipe [NUM_STAGE-1];

    // Sideband bit i lines up with operand register (i=0) or product slot i-1.
    logic [NUM_STAGE-1:0] r_sb_valid;
    logic [NUM_STAGE-1:0] r_sb_first;
    logic [NUM_STAGE-1:0] r_sb_last;

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic                        r_acc_sat;
    logic                        r_res_valid;

    logic signed [SW-1:0] r_rnd;
    logic                 r_rnd_sat;
    logic                 r_rnd_valid;

    logic signed [SW-1:0]        w_prod_ext;
    logic signed [SW-1:0]        w_base;
    logic signed [SW-1:0]        w_sum;
    logic                        w_acc_hi;
    logic                        w_acc_lo;
    logic signed [ACC_WIDTH-1:0] w_sum_clamped;
    logic                        w_sat_next;
    logic signed [SW-1:0]        w_acc_ext;
    logic signed [SW-1:0]        w_rnd;
    logic                        w_out_hi;
    logic                        w_out_lo;
    logic signed [OUT_WIDTH-1:0] w_out_clamped;

    always_ff @(posedge clk) begin
        if (ce) begin
            r_a       <= in_a;
            r_b       <= in_b;
            r_pipe[0] <= PW'(r_a) * PW'(r_b);
            for (int i = 1; i < NUM_STAGE-1; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sb_valid <= '0;
            r_sb_first <= '0;
            r_sb_last  <= '0;
        end else if (ce) begin
            r_sb_valid <= {r_sb_valid[NUM_STAGE-2:0], in_valid};
            r_sb_first <= {r_sb_first[NUM_STAGE-2:0], in_first};
            r_sb_last  <= {r_sb_last[NUM_STAGE-2:0], in_last};
        end
    end

    // Accumulate one bit wider than ACC so the clamp sees true overflow.
    always_comb begin
        w_prod_ext    = SW'(r_pipe[NUM_STAGE-2]);
        w_base        = r_sb_first[TOP] ? '0 : SW'(r_acc);
        w_sum         = w_base + w_prod_ext;
        w_acc_hi      = (w_sum > ACC_MAX);
        w_acc_lo      = (w_sum < ACC_MIN);
        w_sum_clamped = w_sum[ACC_WIDTH-1:0];
        if (w_acc_hi) begin
            w_sum_clamped = ACC_MAX[ACC_WIDTH-1:0];
        end else if (w_acc_lo) begin
            w_sum_clamped = ACC_MIN[ACC_WIDTH-1:0];
        end
        w_sat_next = (r_sb_first[TOP] ? 1'b0 : r_acc_sat) | w_acc_hi | w_acc_lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_acc_sat   <= 1'b0;
            r_res_valid <= 1'b0;
        end else if (ce) begin
            r_res_valid <= r_sb_valid[TOP] & r_sb_last[TOP];
            if (r_sb_valid[TOP]) begin
                r_acc     <= w_sum_clamped;
                r_acc_sat <= w_sat_next;
            end
        end
    end

    // r_acc still holds the frame result here even if the next frame's first
    // product is accumulating in the same cycle.
    assign w_acc_ext = SW'(r_acc);

    generate
        if (FRAC_SHIFT > 0) begin : g_round
            assign w_rnd = (w_acc_ext + ROUND) >>> FRAC_SHIFT;
        end else begin : g_no_round
            assign w_rnd = w_acc_ext;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rnd_valid <= 1'b0;
        end else if (ce) begin
            r_rnd_valid <= r_res_valid;
            r_rnd       <= w_rnd;
            r_rnd_sat   <= r_acc_sat;
        end
    end

    always_comb begin
        w_out_hi      = (r_rnd > OUT_MAX);
        w_out_lo      = (r_rnd < OUT_MIN);
        w_out_clamped = r_rnd[OUT_WIDTH-1:0];
        if (w_out_hi) begin
            w_out_clamped = OUT_MAX[OUT_WIDTH-1:0];
        end else if (w_out_lo) begin
            w_out_clamped = OUT_MIN[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (ce) begin
            out_valid <= r_rnd_valid;
            if (r_rnd_valid) begin
                out_data <= w_out_clamped;
                out_sat  <= r_rnd_sat | w_out_hi | w_out_lo;
            end
        end
    end

endmodule

// File: tb/tb_network_mac_pipe.sv
// Randomised scoreboard bench for network_mac_pipe: a frame-level reference
// model predicts each result and the ce-cycle on which it must appear.
module tb_network_mac_pipe;

    localparam int AW    = 15;
    localparam int BW    = 16;
    localparam int NS    = 3;
    localparam int ACC_W = 40;
    localparam int OW    = 16;
    localparam int FS    = 8;
    localparam int LAT   = NS + 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 ce;
    logic                 in_valid;
    logic signed [AW-1:0] in_a;
    logic signed [BW-1:0] in_b;
    logic                 in_first;
    logic                 in_last;
    logic                 out_valid;
    logic signed [OW-1:0] out_data;
    logic                 out_sat;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    network_mac_pipe #(
        .A_WIDTH(AW), .B_WIDTH(BW), .NUM_STAGE(NS),
        .ACC_WIDTH(ACC_W), .OUT_WIDTH(OW), .FRAC_SHIFT(FS)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat)
    );

    typedef struct {
        logic signed [OW-1:0] data;
        logic                 sat;
        int                   due;
    } exp_t;

    exp_t   sb_q[$];
    longint m_acc = 0;
    logic   m_sat = 1'b0;
    int     ce_count = 0;
    logic   ce_q = 1'b0;
    logic   rst_q = 1'b0;

    always @(posedge clk) begin
        ce_q  <= ce;
        rst_q <= reset;
        if (ce) ce_count <= ce_count + 1;
    end

    function automatic void check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (ce cycle %0d)", name, act, exp, ce_count);
        end
    endfunction

    // Reference: exact integer dot product with per-term clamping, then
    // floor((R + 2^(FS-1)) / 2^FS) clamped to the output range.
    function automatic void model(input logic signed [AW-1:0] a, input logic signed [BW-1:0] b,
                                  input logic f, input logic l);
        longint acc_max = (longint'(1) <<< (ACC_W-1)) - 1;
        longint acc_min = -(longint'(1) <<< (ACC_W-1));
        longint out_max = (longint'(1) <<< (OW-1)) - 1;
        longint out_min = -(longint'(1) <<< (OW-1));
        longint r;
        logic   osat;
        exp_t   e;
        if (f) begin
            m_acc = 0;
            m_sat = 1'b0;
        end
        m_acc = m_acc + longint'(a) * longint'(b);
        if (m_acc > acc_max) begin
            m_acc = acc_max;
            m_sat = 1'b1;
        end else if (m_acc < acc_min) begin
            m_acc = acc_min;
            m_sat = 1'b1;
        end
        if (l) begin
            if (FS > 0) r = (m_acc + (longint'(1) <<< (FS-1))) >>> FS;
            else        r = m_acc;
            osat = 1'b0;
            if (r > out_max) begin
                r = out_max;
                osat = 1'b1;
            end else if (r < out_min) begin
                r = out_min;
                osat = 1'b1;
            end
            e.data = OW'(r);
            e.sat  = m_sat | osat;
            e.due  = ce_count + 1 + LAT;
            sb_q.push_back(e);
        end
    endfunction

    // Monitor: one pop per ce-qualified out_valid; outputs must freeze under ce=0.
    logic                 prev_valid = 1'b0;
    logic signed [OW-1:0] prev_data  = '0;
    logic                 prev_sat   = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!ce_q && !rst_q) begin
            check("hold_valid", out_valid, prev_valid);
            check("hold_data", out_data, prev_data);
            check("hold_sat", out_sat, prev_sat);
        end else if (ce_q && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got data=%0d sat=%0d, expected no result (ce cycle %0d)",
                         out_data, out_sat, ce_count);
            end else begin
                e = sb_q.pop_front();
                $display("[TB] result data=%0d sat=%0d ce_cycle=%0d", out_data, out_sat, ce_count);
                check("out_data", out_data, e.data);
                check("out_sat", out_sat, e.sat);
                check("latency", ce_count, e.due);
            end
        end
        prev_valid <= out_valid;
        prev_data  <= out_data;
        prev_sat   <= out_sat;
    end

    task automatic drive(input logic v, input logic signed [AW-1:0] a, input logic signed [BW-1:0] b,
                         input logic f, input logic l);
        @(negedge clk);
        reset    = 1'b0;
        ce       = 1'b1;
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_first = f;
        in_last  = l;
        if (v) model(a, b, f, l);
    endtask

    task automatic bubble();
        drive(1'b0, AW'($urandom), BW'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bubble();
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset    = 1'b0;
            ce       = 1'b0;
            in_valid = 1'($urandom);
            in_a     = AW'($urandom);
            in_b     = BW'($urandom);
            in_first = 1'($urandom);
            in_last  = 1'($urandom);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset    = 1'b1;
            ce       = 1'($urandom);
            in_valid = 1'($urandom);
            in_a     = AW'($urandom);
            in_b     = BW'($urandom);
            in_first = 1'($urandom);
            in_last  = 1'($urandom);
            sb_q.delete();
            m_acc = 0;
            m_sat = 1'b0;
        end
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sat", out_sat, 0);
        reset    = 1'b0;
        ce       = 1'b1;
        in_valid = 1'b0;
    endtask

    function automatic logic signed [AW-1:0] rand_a(input int mode);
        if (mode == 0) return AW'(int'($urandom_range(510)) - 255);
        return AW'($urandom);
    endfunction

    function automatic logic signed [BW-1:0] rand_b(input int mode);
        if (mode == 0) return BW'(int'($urandom_range(510)) - 255);
        return BW'($urandom);
    endfunction

    initial begin
        int len;
        int mode;
        reset    = 1'b1;
        ce       = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_first = 1'b0;
        in_last  = 1'b0;
        do_reset(3);

        // Single term and a four-term frame with one bubble.
        drive(1'b1, AW'(256), BW'(256), 1'b1, 1'b1);
        idle(3);
        drive(1'b1, AW'(100), BW'(200), 1'b1, 1'b0);
        drive(1'b1, AW'(100), BW'(200), 1'b0, 1'b0);
        bubble();
        drive(1'b1, AW'(100), BW'(200), 1'b0, 1'b0);
        drive(1'b1, AW'(100), BW'(200), 1'b0, 1'b1);
        idle(2);

        // Rounding boundaries, back to back.
        drive(1'b1, AW'(-1), BW'(129), 1'b1, 1'b1);
        drive(1'b1, AW'(-1), BW'(128), 1'b1, 1'b1);
        drive(1'b1, AW'(1), BW'(128), 1'b1, 1'b1);
        idle(2);

        // Output clamp, then a clean frame clears the flag.
        drive(1'b1, AW'(-16384), BW'(-32768), 1'b1, 1'b1);
        drive(1'b1, AW'(3), BW'(4), 1'b1, 1'b1);
        idle(6);

        // Accumulator clamp, then continuation back into output range keeps sticky sat.
        for (int i = 0; i < 1100; i++)
            drive(1'b1, AW'(-16384), BW'(-32768), (i == 0), (i == 1099));
        for (int i = 0; i < 1024; i++)
            drive(1'b1, AW'(-16384), BW'(32767), 1'b0, 1'b0);
        drive(1'b1, AW'(-16384), BW'(1024), 1'b0, 1'b1);
        idle(6);

        // ce stalls mid-frame and while the result is in flight.
        drive(1'b1, AW'(1000), BW'(-37), 1'b1, 1'b0);
        drive(1'b1, AW'(-77), BW'(512), 1'b0, 1'b0);
        stall(3);
        drive(1'b1, AW'(33), BW'(33), 1'b0, 1'b0);
        drive(1'b1, AW'(2048), BW'(9), 1'b0, 1'b1);
        idle(2);
        stall(3);
        idle(6);

        // Reset mid-frame; the fresh frame must not see pre-reset terms.
        drive(1'b1, AW'(5000), BW'(5000), 1'b1, 1'b0);
        drive(1'b1, AW'(5000), BW'(5000), 1'b0, 1'b0);
        drive(1'b1, AW'(5000), BW'(5000), 1'b0, 1'b1);
        do_reset(2);
        drive(1'b1, AW'(300), BW'(7), 1'b1, 1'b1);
        idle(6);

        // Randomised frames with bubbles, stalls, continuations and resets.
        for (int f = 0; f < 250; f++) begin
            len  = int'($urandom_range(6, 1));
            mode = ($urandom_range(3) == 0) ? 1 : 0;
            for (int t = 0; t < len; t++) begin
                if ($urandom_range(3) == 0) bubble();
                if ($urandom_range(9) == 0) stall(int'($urandom_range(3, 1)));
                drive(1'b1, rand_a(mode), rand_b(mode),
                      (t == 0) && ($urandom_range(7) != 0), (t == len-1));
                if ($urandom_range(59) == 0) do_reset(int'($urandom_range(2, 1)));
            end
            if ($urandom_range(19) == 0) do_reset(1);
            idle(int'($urandom_range(2)));
        end

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) bubble();
        idle(2);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/network_mac_pipe.md
# network_mac_pipe

Parametrised, pipelined signed multiply-accumulate unit for the convolution datapath. It generalises the fixed 15×16 three-stage multiplier with configurable operand widths, configurable pipeline depth and a valid-qualified accumulator. It also adds frame delimiting (first/last), fixed-point rescaling with round-half-up, and saturation with a flag. One instance computes one output pixel/channel dot product per frame of operand pairs.

## Interface
Parameters:
- A_WIDTH, 15, signed operand A width (2..25)
- B_WIDTH, 16, signed operand B width (2..18)
- NUM_STAGE, 3, multiplier latency in cycles, input register to product register (2..6)
- ACC_WIDTH, 40, signed accumulator width; must be ≥ A_WIDTH+B_WIDTH-1
- OUT_WIDTH, 16, signed result width; must be ≤ ACC_WIDTH-FRAC_SHIFT
- FRAC_SHIFT, 8, arithmetic right shift applied to the accumulator at output (0..ACC_WIDTH-2)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable; when 0 every register holds, including outputs
- in_valid  in  1  operand pair valid this cycle
- in_a  in  A_WIDTH  signed operand A
- in_b  in  B_WIDTH  signed operand B
- in_first  in  1  pair starts a new accumulation (qualified by in_valid)
- in_last  in  1  pair ends the accumulation and requests a result (qualified by in_valid)
- out_valid  out  1  result valid
- out_data  out  OUT_WIDTH  rescaled, rounded, saturated result
- out_sat  out  1  saturation occurred in the accumulator or at output for this result

## Operation
- Multiplier pipe: in_a/in_b registered, then product P = A*B (A_WIDTH+B_WIDTH bits, signed), padded with (NUM_STAGE-2) further registers. in_valid, in_first, in_last travel alongside in a NUM_STAGE-deep sideband shift register.
- Accumulate stage, on a valid product: base = 0 if first else ACC; sum = sext(base) + sext(P), computed at ACC_WIDTH+1 bits. Sum is clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Clamping sets sticky acc_sat; first clears acc_sat before the update.
- Valid product without first continues the current accumulation (ACC = 0 after reset).
- first and last on the same pair: single-term result.
- Output stage, triggered by a last product: uses the just-updated sum R. If FRAC_SHIFT>0, R' = (R + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT (round half toward +inf), computed at ACC_WIDTH+1 bits; if FRAC_SHIFT=0, R' = R. R' is clamped to the OUT_WIDTH signed range.
- out_sat = acc_sat (including this beat) OR output clamp.
- After last, ACC keeps its value; the next pair should carry first. Absent first, accumulation continues from the clamped sum.
- in_valid=0 cycles inside a frame are bubbles and do not disturb ACC.
- ce=0: all pipeline, sideband, ACC and output registers hold; inputs are ignored that cycle.
- reset (while ce any): clears sideband valids, ACC, acc_sat, out_valid, out_data, out_sat to 0 next edge. Data-path operand/product registers need not be reset. An in-flight frame is discarded; the first result after reset requires a new frame.

## Timing
- Reset values: out_valid=0, out_data=0, out_sat=0.
- Latency, all ce=1: a pair with in_last accepted at edge k gives out_valid=1 after edge k+NUM_STAGE+2 (5 cycles at default).
- out_valid is a one-ce-cycle pulse per last. It remains asserted across ce=0 cycles and drops at the next ce=1 edge that carries no new result.
- Throughput: one pair per cycle, no backpressure. Back-to-back single-term frames give out_valid on consecutive cycles.
- Each ce=0 cycle delays all outputs by exactly one cycle.

## Test plan
- Single term, defaults: a=256, b=256, first=last=1 at edge 0 -> out_valid at edge 5, out_data=256, out_sat=0.
- Four-term frame: four pairs a=100, b=200, first on #1, last on #4, one bubble between #2 and #3 -> ACC=80000, out_data=313, out_sat=0, single out_valid pulse.
- Rounding: a=-1, b=129 -> -1; a=-1, b=128 -> 0; a=1, b=128 -> 1; all frames single-term, results on three consecutive cycles.
- Output saturation: a=-16384, b=-32768 single term -> out_data=32767, out_sat=1; next frame a=3, b=4 -> out_data=0, out_sat=0.
- Accumulator saturation (ACC_WIDTH=32): five pairs a=-16384, b=-32768 -> ACC clamps at 2147483647, out_data=32767, out_sat=1.
- ce stall and reset: ce low 3 cycles mid-frame -> result delayed exactly 3 cycles, same value. reset mid-frame -> outputs 0, no out_valid until a fresh frame, whose result excludes pre-reset terms.
